// File: rtl/fabric_credit_sender.sv
// fabric_credit_sender
// Transmit end of a credit-based fabric link. A local valid/ready stream is
// turned into a registered, credit-gated valid/data stream toward a remote
// receive FIFO of depth CREDITS. The remote side returns one credit pulse per
// entry it pops, so there is no backpressure wire on the link itself.
//
// Handshake: a flit moves on a rising edge where in_valid && in_ready are
// both high. in_ready depends only on registered state, never on in_valid or
// credit_return in the same cycle. A producer may hold in_valid high while
// in_ready is low; the flit is simply taken on the first edge where in_ready
// is high. Toward the link, tx_valid is a one-cycle pulse per flit with no
// ready: the credit count guarantees the remote FIFO has room.

module fabric_credit_sender #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = 0,
    parameter int unsigned CREDITS    = 4,
    localparam int unsigned PAYLOAD_WIDTH = DATA_WIDTH + TAG_WIDTH,
    localparam int unsigned CNT_WIDTH     = $clog2(CREDITS + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PAYLOAD_WIDTH-1:0] in_data,
    output logic                     tx_valid,
    output logic [PAYLOAD_WIDTH-1:0] tx_data,
    input  logic                     credit_return,
    output logic [CNT_WIDTH-1:0]     credit_count,
    output logic                     idle,
    output logic                     err_overflow
);

    // Full credit level (all remote FIFO entries free) and a unit step.
    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(CREDITS);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    // Registered state.
    logic [CNT_WIDTH-1:0]     credit_q,       credit_d;
    logic                     tx_valid_q,     tx_valid_d;
    logic [PAYLOAD_WIDTH-1:0] tx_data_q,      tx_data_d;
    logic                     err_overflow_q, err_overflow_d;

    // Combinational helpers.
    logic ready_w;
    logic accept_w;
    logic overflow_evt_w;

    // Ready comes straight from the credit register; accept is the handshake.
    always_comb begin
        ready_w  = (credit_q != '0);
        accept_w = in_valid && ready_w;
    end

    // Credit counter: an accept spends one credit, a return refunds one, and
    // both together cancel. A lone return while already full is an error and
    // the count saturates instead of wrapping.
    always_comb begin
        credit_d       = credit_q;
        overflow_evt_w = 1'b0;
        unique case ({accept_w, credit_return})
            2'b10: credit_d = credit_q - CNT_ONE;
            2'b01: begin
                if (credit_q == CNT_FULL) begin
                    overflow_evt_w = 1'b1;
                end else begin
                    credit_d = credit_q + CNT_ONE;
                end
            end
            default: credit_d = credit_q;
        endcase
    end

    // Overflow flag is sticky until reset.
    always_comb begin
        err_overflow_d = err_overflow_q | overflow_evt_w;
    end

    // Output stage: one-cycle valid per accepted flit, data held otherwise.
    always_comb begin
        tx_valid_d = accept_w;
        tx_data_d  = accept_w ? in_data : tx_data_q;
    end

    // State registers; reset discards any flit in flight and refills credits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q       <= CNT_FULL;
            tx_valid_q     <= 1'b0;
            tx_data_q      <= '0;
            err_overflow_q <= 1'b0;
        end else begin
            credit_q       <= credit_d;
            tx_valid_q     <= tx_valid_d;
            tx_data_q      <= tx_data_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    // Outputs are all register-derived.
    assign in_ready     = ready_w;
    assign tx_valid     = tx_valid_q;
    assign tx_data      = tx_data_q;
    assign credit_count = credit_q;
    assign err_overflow = err_overflow_q;
    assign idle         = (credit_q == CNT_FULL) && !tx_valid_q;

endmodule

// File: tb/tb_fabric_credit_sender.sv
// Bench for fabric_credit_sender: directed scenarios with literal expectations,
// an outstanding-flit model compared every cycle, and a random phase against a
// behavioural remote FIFO that returns credits.

module tb_fabric_credit_sender;

    localparam int DW = 32;
    localparam int TW = 4;
    localparam int CR = 4;
    localparam int PW = DW + TW;
    localparam int CW = $clog2(CR + 1);

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // stimulus
    logic          in_valid   = 1'b0;
    logic [PW-1:0] in_data    = '0;
    logic          dir_credit = 1'b0;
    logic          rem_credit = 1'b0;
    logic          remote_en  = 1'b0;
    logic          credit_return;
    assign credit_return = remote_en ? rem_credit : dir_credit;

    // DUT outputs (tagged instance)
    logic          in_ready, tx_valid, idle, err_overflow;
    logic [PW-1:0] tx_data;
    logic [CW-1:0] credit_count;

    // DUT outputs (untagged instance, TAG_WIDTH = 0)
    logic          in_ready0, tx_valid0, idle0, err_overflow0;
    logic [DW-1:0] tx_data0;
    logic [CW-1:0] credit_count0;

    fabric_credit_sender #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .CREDITS(CR)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .tx_valid(tx_valid), .tx_data(tx_data),
        .credit_return(credit_return), .credit_count(credit_count),
        .idle(idle), .err_overflow(err_overflow)
    );

    fabric_credit_sender #(.DATA_WIDTH(DW), .TAG_WIDTH(0), .CREDITS(CR)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data[DW-1:0]), .tx_valid(tx_valid0), .tx_data(tx_data0),
        .credit_return(credit_return), .credit_count(credit_count0),
        .idle(idle0), .err_overflow(err_overflow0)
    );

    // counters
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Model: tracks flits outstanding at the remote side rather than credits.
    int            m_out      = 0;
    logic          m_tx_valid = 1'b0;
    logic [PW-1:0] m_tx_data  = '0;
    logic          m_err      = 1'b0;
    logic          m_acc      = 1'b0;
    int            n_acc      = 0;
    logic [PW-1:0] exp_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_out      = 0;
            m_tx_valid = 1'b0;
            m_tx_data  = '0;
            m_err      = 1'b0;
            exp_q.delete();
        end else begin
            m_acc      = in_valid && (m_out < CR);
            m_tx_valid = m_acc;
            if (m_acc) begin
                m_tx_data = in_data;
                m_out++;
                n_acc++;
                exp_q.push_back(in_data);
            end
            if (credit_return) begin
                if (m_out > 0) m_out--;
                else m_err = 1'b1;
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            check("tx_valid", tx_valid, m_tx_valid);
            check("tx_data", tx_data, m_tx_data);
            check("credit_count", credit_count, CR - m_out);
            check("in_ready", in_ready, m_out < CR);
            check("idle", idle, (m_out == 0) && !m_tx_valid);
            check("err_overflow", err_overflow, m_err);
            check("u0_tx_valid", tx_valid0, m_tx_valid);
            check("u0_tx_data", tx_data0, m_tx_data[DW-1:0]);
            check("u0_credit_count", credit_count0, CR - m_out);
        end
    end

    // Behavioural remote FIFO: receives flits, pops at random, returns credits.
    int rx_cnt   = 0;
    int rx_depth = 0;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_cnt     = 0;
            rx_depth   = 0;
            rem_credit = 1'b0;
        end else if (remote_en) begin
            if (tx_valid) begin
                if (rx_cnt < exp_q.size()) check("rx_order", tx_data, exp_q[rx_cnt]);
                else check("rx_unexpected_flit", 1, 0);
                rx_cnt++;
                rx_depth++;
                check("rx_fifo_no_overflow", rx_depth <= CR, 1);
            end
            rem_credit = 1'b0;
            if (rx_depth > 0 && $urandom_range(0, 1) == 1) begin
                rx_depth--;
                rem_credit = 1'b1;
            end
        end else begin
            rem_credit = 1'b0;
        end
    end

    task automatic do_reset();
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        dir_credit = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        check("rst_credit_count", credit_count, CR);
        check("rst_in_ready", in_ready, 1);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_idle", idle, 1);
        check("rst_err_overflow", err_overflow, 0);
    endtask

    // Watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed and random stimulus.
    initial begin
        int base;
        int cyc;

        do_reset();

        // Single push.
        in_valid = 1'b1;
        in_data  = 36'h2A;
        tick();
        check("single_tx_valid", tx_valid, 1);
        check("single_tx_data", tx_data, 36'h2A);
        in_valid = 1'b0;
        tick();
        check("single_tx_valid_drop", tx_valid, 0);
        check("single_credit", credit_count, 3);
        check("single_idle", idle, 0);
        check("single_data_hold", tx_data, 36'h2A);

        // Four back-to-back flits drain all credits.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 36'h64 + 36'(i);
            tick();
            check("b2b_tx_valid", tx_valid, 1);
            check("b2b_tx_data", tx_data, 36'h64 + 36'(i));
        end
        check("b2b_credit_empty", credit_count, 0);
        check("b2b_ready_low", in_ready, 0);
        in_data = 36'h68;
        tick();
        check("fifth_held_off", tx_valid, 0);
        tick();
        check("fifth_still_held", tx_valid, 0);
        check("fifth_data_hold", tx_data, 36'h67);

        // One credit back at empty: ready rises only after the edge.
        in_valid   = 1'b0;
        dir_credit = 1'b1;
        #1;
        check("ready_no_comb_path", in_ready, 0);
        tick();
        dir_credit = 1'b0;
        check("ready_after_return", in_ready, 1);
        check("credit_after_return", credit_count, 1);

        // Accept and return together for ten cycles.
        for (int i = 0; i < 10; i++) begin
            in_valid   = 1'b1;
            dir_credit = 1'b1;
            in_data    = 36'h70 + 36'(i);
            tick();
            check("stream_tx_valid", tx_valid, 1);
            check("stream_tx_data", tx_data, 36'h70 + 36'(i));
            check("stream_credit", credit_count, 1);
        end
        in_valid   = 1'b0;
        dir_credit = 1'b0;
        tick();
        check("stream_end_valid", tx_valid, 0);
        check("stream_end_credit", credit_count, 1);

        // Asynchronous reset with a flit in flight.
        in_valid = 1'b1;
        in_data  = 36'h99;
        tick();
        in_valid = 1'b0;
        check("inflight_tx_valid", tx_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_tx_valid", tx_valid, 0);
        check("async_rst_credit", credit_count, CR);
        tick();
        rst_n = 1'b1;

        // Accept plus return while full is legal.
        in_valid   = 1'b1;
        dir_credit = 1'b1;
        in_data    = {4'hA, 32'h55};
        tick();
        check("full_both_credit", credit_count, CR);
        check("full_both_err", err_overflow, 0);
        check("full_both_tag_data", tx_data, {4'hA, 32'h55});
        in_valid   = 1'b0;
        dir_credit = 1'b0;

        // Lone return while full: saturate and set the sticky error.
        dir_credit = 1'b1;
        tick();
        dir_credit = 1'b0;
        check("ovf_credit_saturate", credit_count, CR);
        check("ovf_err_set", err_overflow, 1);
        repeat (20) tick();
        check("ovf_err_sticky", err_overflow, 1);
        do_reset();

        // Random traffic against the remote FIFO model.
        remote_en = 1'b1;
        base = n_acc;
        cyc  = 0;
        while ((n_acc - base) < 1000 && cyc < 20000) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = {4'($urandom_range(0, 15)), 32'($urandom)};
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        check("rand_flits_accepted", n_acc - base, 1000);
        cyc = 0;
        while (!(rx_depth == 0 && idle) && cyc < 200) begin
            tick();
            cyc++;
        end
        check("rand_drain_in_time", cyc < 200, 1);
        check("rand_idle_end", idle, 1);
        check("rand_err_clear", err_overflow, 0);
        check("rand_all_arrived", rx_cnt, 1000);
        remote_en = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fabric_credit_sender.md
Name: fabric_credit_sender

Overview:
- Transmit end of the credit-based fabric link. Converts a local valid/ready stream into a registered, credit-gated valid/data stream toward a remote receive FIFO of known depth.
- The remote FIFO returns one credit pulse per entry it pops, so the link carries no backpressure wire.
- Sits upstream of long or retimed fabric routes where a combinational ready path is not permitted.

Parameters:
- DATA_WIDTH, 32, payload data bits.
- TAG_WIDTH, 0, tag bits carried above data; PAYLOAD_WIDTH = DATA_WIDTH + TAG_WIDTH.
- CREDITS, 4, remote FIFO depth; initial credit count; legal range 1..256.
- CNT_WIDTH, $clog2(CREDITS+1), derived (localparam); credit counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  local producer has a flit.
- in_ready  out  1  sender can accept a flit this cycle.
- in_data  in  PAYLOAD_WIDTH  flit payload, {tag, data}.
- tx_valid  out  1  registered flit-valid toward the remote FIFO; single-cycle per flit.
- tx_data  out  PAYLOAD_WIDTH  registered flit payload.
- credit_return  in  1  one credit returned per cycle it is high.
- credit_count  out  CNT_WIDTH  current available credits.
- idle  out  1  all credits home and no flit in flight on tx.
- err_overflow  out  1  sticky: a credit was returned while credit_count == CREDITS.

Behaviour:
- Reset (async assert, sync release):
  - credit_count = CREDITS.
  - tx_valid = 0, tx_data = 0, err_overflow = 0.
  - in_ready = 1, idle = 1 once reset is released.
- in_ready = (credit_count != 0).
  - Purely from registered state; no combinational path from credit_return or in_valid.
- Accept = in_valid && in_ready, sampled at the rising edge.
- On the edge after accept: tx_valid = 1 and tx_data = in_data. Latency is exactly 1 cycle.
- On a cycle with no accept: tx_valid = 0 and tx_data holds its last value.
- Back-to-back accepts yield tx_valid high on consecutive cycles, in order.
- credit_count next-state, by case:
  - Accept only: count − 1.
  - credit_return only: count + 1.
  - Accept and credit_return in the same cycle: unchanged.
  - Neither: unchanged.
- Empty boundary: at count == 0, in_ready = 0.
  - A credit_return at count == 0 raises in_ready on the next cycle, not the same cycle.
- Overflow: credit_return with no accept at count == CREDITS:
  - count saturates at CREDITS;
  - err_overflow sets to 1 and stays set until reset.
  - The same-cycle accept-plus-return case at count == CREDITS is legal and does not set the error.
- Counter never underflows, since accept requires count != 0.
- idle = (credit_count == CREDITS) && !tx_valid.
- Reset asserted mid-operation:
  - Immediately clears tx_valid and restores credit_count = CREDITS.
  - Flits in flight are discarded. The remote FIFO must be reset together with the sender.
- Tag bits pass unmodified. TAG_WIDTH = 0 must elaborate cleanly.

Test Plan:
- Reset with CREDITS=4 → credit_count=4, in_ready=1, tx_valid=0, idle=1, err_overflow=0.
- Single push of in_data=0x2A, no returns → next cycle tx_valid=1, tx_data=0x2A; following cycle tx_valid=0, credit_count=3, idle=0.
- Push 4 flits back-to-back (0x64..0x67), no returns:
  - tx_valid high 4 consecutive cycles carrying 0x64..0x67 in order;
  - credit_count=0 and in_ready=0 afterwards;
  - a 5th in_valid is held off.
- At credit_count=0, pulse credit_return once → in_ready=1 on the next cycle. Then hold in_valid and credit_return together for 10 cycles → count stays 1 and 10 flits are emitted.
- At credit_count=CREDITS, pulse credit_return with in_valid=0 → count stays 4 and err_overflow=1. err_overflow remains 1 through 20 further cycles and clears only on rst_n.
- Randomized traffic: 1000 flits, random in_valid at 75%, and a behavioural remote FIFO of depth CREDITS that pops at random and returns credits.
  - Every flit arrives in order.
  - The remote FIFO never overflows.
  - err_overflow stays 0.
  - idle=1 at the end.
